// File: rtl/simple_pkg.sv
// Shared constants and helpers for the SIMPLE multi-cycle datapath phases.
// Field encodings used by the writeback phase live here so all phases agree.
package simple_pkg;

  localparam logic [2:0] PH_WB     = 3'd4;
  localparam int         REG_AW    = 3;

  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_UNCOND = 2'b01;
  localparam logic [1:0] BR_COND   = 2'b10;

  localparam logic [2:0] CC_BE     = 3'd0;
  localparam logic [2:0] CC_BLT    = 3'd1;
  localparam logic [2:0] CC_BLE    = 3'd2;
  localparam logic [2:0] CC_BNE    = 3'd3;

  localparam logic       WB_ALU    = 1'b0;
  localparam logic       WB_MEM    = 1'b1;

  localparam int SZCV_S = 3;
  localparam int SZCV_Z = 2;
  localparam int SZCV_C = 1;
  localparam int SZCV_V = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_e;

  // Codes 4-7 are deliberately never taken.
  function automatic logic cc_taken(input logic [2:0] cc, input logic [3:0] flags);
    logic lt;
    lt = flags[SZCV_S] ^ flags[SZCV_V];
    case (cc)
      CC_BE:   cc_taken = flags[SZCV_Z];
      CC_BLT:  cc_taken = lt;
      CC_BLE:  cc_taken = flags[SZCV_Z] | lt;
      CC_BNE:  cc_taken = ~flags[SZCV_Z];
      default: cc_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/p5_regfile.sv
// General register file: NREG x WIDTH, async reset, two combinational
// read ports and one negedge write port.
module p5_regfile
  import simple_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int AW    = REG_AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] reg_q [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [WIDTH-1:0] q_reg;

      always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
          q_reg <= '0;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          q_reg <= wr_data;
        end
      end

      assign reg_q[gi] = q_reg;
    end
  endgenerate

  // Reads see pre-commit contents until the committing negedge.
  assign ra_data = reg_q[ra_addr];
  assign rb_data = reg_q[rb_addr];

endmodule

// File: rtl/p5_writeback.sv
// Writeback phase: commits registers, SZCV, PC, output port and the halt
// latch on the phase-4 negedge, and serves the ALU operand read ports.
module p5_writeback
  import simple_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       phase_counter,
  input  logic [15:0]      instruction_register,
  input  logic [WIDTH-1:0] data_register,
  input  logic [WIDTH-1:0] mem_read_data,
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] program_counter_pre,
  input  logic             op_reg_write,
  input  logic             op_wb_src,
  input  logic             op_cond_write,
  input  logic [1:0]       op_branch,
  input  logic             op_out_write,
  input  logic             op_halt,
  output logic [WIDTH-1:0] ar,
  output logic [WIDTH-1:0] br,
  output logic [3:0]       szcv,
  output logic [WIDTH-1:0] program_counter,
  output logic [WIDTH-1:0] outp,
  output logic             halted
);

  logic [REG_AW-1:0] rs_idx;
  logic [REG_AW-1:0] rd_idx;
  logic [2:0]        cc_field;
  logic              unused_ir;

  assign rs_idx    = instruction_register[13:11];
  assign rd_idx    = instruction_register[10:8];
  assign cc_field  = instruction_register[10:8];
  assign unused_ir = ^{instruction_register[15:14], instruction_register[7:0]};

  wb_state_e        state_reg, state_next;
  logic [3:0]       szcv_reg, szcv_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] outp_reg, outp_next;
  logic [WIDTH-1:0] ar_data, br_data;
  logic [WIDTH-1:0] wb_data;
  logic             commit;
  logic             taken;
  logic             reg_we;

  assign commit = (phase_counter == PH_WB) && (state_reg == ST_RUN);

  p5_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .AW    (REG_AW)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .ra_addr (rs_idx),
    .rb_addr (rd_idx),
    .ra_data (ar_data),
    .rb_data (br_data),
    .wr_en   (reg_we),
    .wr_addr (rd_idx),
    .wr_data (wb_data)
  );

  always_comb begin
    state_next = state_reg;
    szcv_next  = szcv_reg;
    pc_next    = pc_reg;
    outp_next  = outp_reg;
    reg_we     = 1'b0;
    taken      = 1'b0;
    wb_data    = (op_wb_src == WB_MEM) ? mem_read_data : data_register;

    // Branch decision looks at the committed flags, not this cycle's cond.
    case (op_branch)
      BR_UNCOND: taken = 1'b1;
      BR_COND:   taken = cc_taken(cc_field, szcv_reg);
      default:   taken = 1'b0;
    endcase

    if (commit) begin
      reg_we  = op_reg_write;
      pc_next = taken ? data_register : program_counter_pre;
      if (op_cond_write) begin
        szcv_next = cond;
      end
      if (op_out_write) begin
        outp_next = br_data;
      end
    end

    case (state_reg)
      ST_RUN:  if (commit && op_halt) state_next = ST_HALT;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_RUN;
      szcv_reg  <= '0;
      pc_reg    <= '0;
      outp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      szcv_reg  <= szcv_next;
      pc_reg    <= pc_next;
      outp_reg  <= outp_next;
    end
  end

  assign ar              = ar_data;
  assign br              = br_data;
  assign szcv            = szcv_reg;
  assign program_counter = pc_reg;
  assign outp            = outp_reg;
  assign halted          = (state_reg == ST_HALT);

endmodule

// File: tb/tb_p5_writeback.sv
// Directed bench for p5_writeback: stimulus queues hand-computed expectations,
// a monitor process drains and compares them against the DUT outputs.
module tb_p5_writeback;
  import simple_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  phase_counter;
  logic [15:0] instruction_register;
  logic [15:0] data_register;
  logic [15:0] mem_read_data;
  logic [3:0]  cond;
  logic [15:0] program_counter_pre;
  logic        op_reg_write;
  logic        op_wb_src;
  logic        op_cond_write;
  logic [1:0]  op_branch;
  logic        op_out_write;
  logic        op_halt;
  logic [15:0] ar;
  logic [15:0] br;
  logic [3:0]  szcv;
  logic [15:0] program_counter;
  logic [15:0] outp;
  logic        halted;

  always #20 clock = ~clock;

  p5_writeback #(.WIDTH(16), .NREG(8)) dut (
    .clock                (clock),
    .reset                (reset),
    .phase_counter        (phase_counter),
    .instruction_register (instruction_register),
    .data_register        (data_register),
    .mem_read_data        (mem_read_data),
    .cond                 (cond),
    .program_counter_pre  (program_counter_pre),
    .op_reg_write         (op_reg_write),
    .op_wb_src            (op_wb_src),
    .op_cond_write        (op_cond_write),
    .op_branch            (op_branch),
    .op_out_write         (op_out_write),
    .op_halt              (op_halt),
    .ar                   (ar),
    .br                   (br),
    .szcv                 (szcv),
    .program_counter      (program_counter),
    .outp                 (outp),
    .halted               (halted)
  );

  typedef enum int {K_AR, K_BR, K_SZCV, K_PC, K_OUTP, K_HALT} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  event chk_now;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [15:0] observe(input kind_e k);
    case (k)
      K_AR:    observe = ar;
      K_BR:    observe = br;
      K_SZCV:  observe = {12'h000, szcv};
      K_PC:    observe = program_counter;
      K_OUTP:  observe = outp;
      default: observe = {15'h0000, halted};
    endcase
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [15:0] got;
    forever begin
      @(posedge clock or chk_now);
      #1;
      while (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = observe(e.kind);
        checks++;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%04h required 0x%04h", e.name, got, e.exp);
        end else begin
          $display("ok   %s: 0x%04h", e.name, got);
        end
      end
    end
  end

  task automatic expect_val(input kind_e k, input logic [15:0] v, input string name);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic flush();
    ->chk_now;
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL monitor_timeout: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clear_ops();
    phase_counter = 3'd0;
    op_reg_write  = 1'b0;
    op_wb_src     = 1'b0;
    op_cond_write = 1'b0;
    op_branch     = BR_NONE;
    op_out_write  = 1'b0;
    op_halt       = 1'b0;
  endtask

  // Inputs change just after a negedge so they are stable from the next posedge.
  task automatic commit(input logic [2:0] ph, input logic [15:0] ir,
                        input logic rw, input logic src, input logic cw,
                        input logic [1:0] brop, input logic ow, input logic hlt,
                        input logic [15:0] dr, input logic [15:0] mrd,
                        input logic [3:0] cc, input logic [15:0] pre);
    @(negedge clock); #1;
    instruction_register = ir;
    op_reg_write         = rw;
    op_wb_src            = src;
    op_cond_write        = cw;
    op_branch            = brop;
    op_out_write         = ow;
    op_halt              = hlt;
    data_register        = dr;
    mem_read_data        = mrd;
    cond                 = cc;
    program_counter_pre  = pre;
    phase_counter        = ph;
    @(negedge clock); #1;
    clear_ops();
  endtask

  typedef struct {
    logic [2:0] cc;
    logic       taken;
  } br_vec_t;

  br_vec_t br_tbl[6];

  initial begin : stimulus
    logic [2:0]  a;
    logic [2:0]  b;
    logic [15:0] exp_pc;

    br_tbl[0] = '{3'd0, 1'b0};
    br_tbl[1] = '{3'd1, 1'b1};
    br_tbl[2] = '{3'd2, 1'b1};
    br_tbl[3] = '{3'd3, 1'b1};
    br_tbl[4] = '{3'd5, 1'b0};
    br_tbl[5] = '{3'd7, 1'b0};

    reset                = 1'b1;
    instruction_register = 16'h0000;
    data_register        = 16'h0000;
    mem_read_data        = 16'h0000;
    cond                 = 4'h0;
    program_counter_pre  = 16'h0000;
    clear_ops();
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;

    // Reset state
    expect_val(K_PC,   16'h0000, "reset_pc");
    expect_val(K_SZCV, 16'h0000, "reset_szcv");
    expect_val(K_OUTP, 16'h0000, "reset_outp");
    expect_val(K_HALT, 16'h0000, "reset_halted");
    expect_val(K_AR,   16'h0000, "reset_ar_r0");
    expect_val(K_BR,   16'h0000, "reset_br_r0");
    flush();

    // Writeback source select on Rd=5
    commit(3'd4, 16'h0500, 1, WB_ALU, 0, BR_NONE, 0, 0, 16'hBEEF, 16'h0000, 4'h0, 16'h0001);
    expect_val(K_BR, 16'hBEEF, "wb_alu_r5");
    expect_val(K_PC, 16'h0001, "wb_alu_pc");
    flush();
    commit(3'd4, 16'h0500, 1, WB_MEM, 0, BR_NONE, 0, 0, 16'h1111, 16'h0042, 4'h0, 16'h0002);
    expect_val(K_BR, 16'h0042, "wb_mem_r5");
    expect_val(K_PC, 16'h0002, "wb_mem_pc");
    flush();
    commit(3'd2, 16'h0500, 1, WB_ALU, 1, BR_UNCOND, 1, 1, 16'h7777, 16'h0000, 4'hF, 16'h0099);
    expect_val(K_BR,   16'h0042, "phase2_r5_hold");
    expect_val(K_PC,   16'h0002, "phase2_pc_hold");
    expect_val(K_SZCV, 16'h0000, "phase2_szcv_hold");
    expect_val(K_HALT, 16'h0000, "phase2_halt_hold");
    flush();

    // Conditional branch evaluates the pre-commit flags
    commit(3'd4, 16'h0000, 0, WB_ALU, 1, BR_NONE, 0, 0, 16'h0000, 16'h0000, 4'b0100, 16'h0010);
    expect_val(K_SZCV, 16'h0004, "set_z");
    flush();
    commit(3'd4, 16'h0000, 0, WB_ALU, 1, BR_COND, 0, 0, 16'h0080, 16'h0000, 4'b0000, 16'h0011);
    expect_val(K_PC,   16'h0080, "be_old_flags_pc");
    expect_val(K_SZCV, 16'h0000, "be_new_szcv");
    flush();
    commit(3'd4, 16'h0000, 0, WB_ALU, 0, BR_COND, 0, 0, 16'h0090, 16'h0000, 4'b0000, 16'h0012);
    expect_val(K_PC, 16'h0012, "be_not_taken_pc");
    flush();

    // Condition-code matrix with S^V=1, Z=0
    commit(3'd4, 16'h0000, 0, WB_ALU, 1, BR_NONE, 0, 0, 16'h0000, 16'h0000, 4'b1000, 16'h0100);
    expect_val(K_SZCV, 16'h0008, "set_s");
    flush();
    for (int i = 0; i < 6; i++) begin
      exp_pc = br_tbl[i].taken ? (16'h2000 | 16'(br_tbl[i].cc)) : (16'h3000 | 16'(br_tbl[i].cc));
      commit(3'd4, {5'b00000, br_tbl[i].cc, 8'h00}, 0, WB_ALU, 0, BR_COND, 0, 0,
             16'h2000 | 16'(br_tbl[i].cc), 16'h0000, 4'h0, 16'h3000 | 16'(br_tbl[i].cc));
      expect_val(K_PC, exp_pc, $sformatf("cc%0d_pc", br_tbl[i].cc));
      flush();
    end
    commit(3'd4, 16'h0000, 0, WB_ALU, 0, BR_UNCOND, 0, 0, 16'hFFFF, 16'h0000, 4'h0, 16'h0001);
    expect_val(K_PC, 16'hFFFF, "uncond_pc");
    flush();
    commit(3'd4, 16'h0000, 0, WB_ALU, 0, 2'b11, 0, 0, 16'h4444, 16'h0000, 4'h0, 16'h0000);
    expect_val(K_PC, 16'h0000, "reserved_br_pc");
    flush();

    // Output port samples Rd before the same-commit write
    commit(3'd4, 16'h0200, 1, WB_ALU, 0, BR_NONE, 0, 0, 16'h0007, 16'h0000, 4'h0, 16'h0020);
    expect_val(K_BR, 16'h0007, "r2_init");
    flush();
    commit(3'd4, 16'h0200, 1, WB_ALU, 0, BR_NONE, 1, 0, 16'h0009, 16'h0000, 4'h0, 16'h0021);
    expect_val(K_OUTP, 16'h0007, "outp_old_r2");
    expect_val(K_BR,   16'h0009, "r2_new");
    flush();

    // Halt honours its own enables, then freezes state
    commit(3'd4, 16'h0100, 1, WB_ALU, 0, BR_NONE, 0, 1, 16'h00AA, 16'h0000, 4'h0, 16'h0040);
    expect_val(K_BR,   16'h00AA, "halt_r1");
    expect_val(K_HALT, 16'h0001, "halt_set");
    expect_val(K_PC,   16'h0040, "halt_pc");
    flush();
    commit(3'd4, 16'h0100, 1, WB_ALU, 1, BR_UNCOND, 1, 0, 16'h5555, 16'h0000, 4'hF, 16'h0041);
    expect_val(K_BR,   16'h00AA, "halted_r1_hold");
    expect_val(K_PC,   16'h0040, "halted_pc_hold");
    expect_val(K_SZCV, 16'h0008, "halted_szcv_hold");
    expect_val(K_OUTP, 16'h0007, "halted_outp_hold");
    expect_val(K_HALT, 16'h0001, "halted_hold");
    flush();
    @(negedge clock); #3 reset = 1'b1;
    #2 reset = 1'b0;
    expect_val(K_HALT, 16'h0000, "reset_clears_halt");
    expect_val(K_BR,   16'h0000, "reset_clears_r1");
    expect_val(K_PC,   16'h0000, "reset_clears_pc");
    flush();

    // Asynchronous reset between edges
    commit(3'd4, 16'h0300, 1, WB_ALU, 0, BR_NONE, 0, 0, 16'h1234, 16'h0000, 4'h0, 16'h0001);
    commit(3'd4, 16'h0300, 0, WB_ALU, 1, BR_UNCOND, 1, 1, 16'h5555, 16'h0000, 4'hF, 16'h0002);
    expect_val(K_BR,   16'h1234, "pre_reset_r3");
    expect_val(K_OUTP, 16'h1234, "pre_reset_outp");
    expect_val(K_SZCV, 16'h000F, "pre_reset_szcv");
    expect_val(K_PC,   16'h5555, "pre_reset_pc");
    expect_val(K_HALT, 16'h0001, "pre_reset_halt");
    flush();
    @(negedge clock); #3 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      a = 3'(2 * i);
      b = 3'(2 * i + 1);
      instruction_register = {2'b00, a, b, 8'h00};
      expect_val(K_AR, 16'h0000, $sformatf("async_reset_r%0d", 2 * i));
      expect_val(K_BR, 16'h0000, $sformatf("async_reset_r%0d", 2 * i + 1));
      flush();
    end
    expect_val(K_SZCV, 16'h0000, "async_reset_szcv");
    expect_val(K_PC,   16'h0000, "async_reset_pc");
    expect_val(K_OUTP, 16'h0000, "async_reset_outp");
    expect_val(K_HALT, 16'h0000, "async_reset_halt");
    flush();
    reset = 1'b0;

    repeat (2) @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
